// File: rtl/instruction_encoder.sv
// Packs R/I/J instruction fields into 32-bit words and streams them into instruction memory.
// Each accepted field set goes IDLE -> ENCODE -> WRITE, so the write strobe comes two cycles after acceptance.
module instruction_encoder #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate_data,
  input  logic [25:0] jump_target,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [8:0]  instr_count,
  output logic        full,
  output logic        err_fmt
);

  localparam logic [8:0] DEPTH_COUNT = 9'(MEM_DEPTH);
  localparam logic [1:0] FMT_R       = 2'b00;
  localparam logic [1:0] FMT_I       = 2'b01;
  localparam logic [1:0] FMT_J       = 2'b10;
  localparam logic [1:0] FMT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    WRITE,
    FULL
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [1:0]  r_fmt;
  logic [5:0]  r_opcode;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [4:0]  r_shamt;
  logic [5:0]  r_funct;
  logic [15:0] r_imm;
  logic [25:0] r_target;

  logic [31:0] r_wdata;
  logic [31:0] r_addr;
  logic [8:0]  r_count;

  logic        w_accept;
  logic        w_legal;
  logic        w_latchWord;
  logic [8:0]  w_countInc;
  logic [31:0] w_encoded;
  logic [31:0] w_slotAddr;

  assign in_ready    = (r_state == IDLE) && !start;
  assign w_accept    = in_valid && in_ready;
  assign w_legal     = (r_fmt != FMT_ILLEGAL);
  assign w_latchWord = (r_state == ENCODE) && w_legal && !start;
  assign w_countInc  = r_count + 9'd1;
  assign w_slotAddr  = BASE_ADDR + {21'd0, r_count, 2'b00};

  // Start is a synchronous abort: it suppresses every strobe in the cycle it is seen.
  assign mem_wr_en   = (r_state == WRITE) && !start;
  assign err_fmt     = (r_state == ENCODE) && !w_legal && !start;
  assign full        = (r_state == FULL);
  assign mem_wdata   = r_wdata;
  assign mem_addr    = r_addr;
  assign instr_count = r_count;

  always_comb begin
    w_encoded = 32'd0;
    case (r_fmt)
      FMT_R:   w_encoded = {r_opcode, r_rs, r_rt, r_rd, r_shamt, r_funct};
      FMT_I:   w_encoded = {r_opcode, r_rs, r_rt, r_imm};
      FMT_J:   w_encoded = {r_opcode, r_target};
      default: w_encoded = 32'd0;
    endcase
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = ENCODE;
      ENCODE:  w_nextState = w_legal ? WRITE : IDLE;
      WRITE:   w_nextState = (w_countInc == DEPTH_COUNT) ? FULL : IDLE;
      FULL:    w_nextState = FULL;
      default: w_nextState = IDLE;
    endcase
    if (start) w_nextState = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fmt    <= 2'b00;
      r_opcode <= 6'd0;
      r_rs     <= 5'd0;
      r_rt     <= 5'd0;
      r_rd     <= 5'd0;
      r_shamt  <= 5'd0;
      r_funct  <= 6'd0;
      r_imm    <= 16'd0;
      r_target <= 26'd0;
    end else if (w_accept) begin
      r_fmt    <= fmt;
      r_opcode <= opcode;
      r_rs     <= rs;
      r_rt     <= rt;
      r_rd     <= rd;
      r_shamt  <= shamt;
      r_funct  <= funct;
      r_imm    <= immediate_data;
      r_target <= jump_target;
    end
  end

  // Word and address are captured together so both stay frozen after the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdata <= 32'd0;
      r_addr  <= BASE_ADDR;
    end else if (w_latchWord) begin
      r_wdata <= w_encoded;
      r_addr  <= w_slotAddr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_count <= 9'd0;
    else if (start)              r_count <= 9'd0;
    else if (r_state == WRITE)   r_count <= w_countInc;
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: a latency-based reference model checked every cycle,
// plus directed scenarios with hand-computed words, addresses and counts.
module tb_instruction_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = 2'b00;
  logic [5:0]  opcode = 6'd0;
  logic [4:0]  rs = 5'd0;
  logic [4:0]  rt = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  shamt = 5'd0;
  logic [5:0]  funct = 6'd0;
  logic [15:0] immediate_data = 16'd0;
  logic [25:0] jump_target = 26'd0;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  instr_count;
  logic        full;
  logic        err_fmt;

  int total = 0;
  int bad = 0;

  instruction_encoder #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate_data(immediate_data), .jump_target(jump_target),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instr_count(instr_count), .full(full), .err_fmt(err_fmt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encodeWord(input logic [1:0] f, input logic [5:0] op,
      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
    logic [31:0] w;
    w = 32'(op) << 26;
    if (f == 2'b00) w = w | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn);
    else if (f == 2'b01) w = w | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
    else w = w | 32'(tg);
    return w;
  endfunction

  // Reference model: tracks when each accepted request must strobe, in absolute cycle numbers.
  int          cyc = 0;
  int          mFreeAt = 0;
  int          mWrAt = -1;
  int          mErrAt = -1;
  int          mCount = 0;
  bit          mFull = 1'b0;
  logic [31:0] mPend = 32'd0;
  logic [31:0] mWord = 32'd0;
  logic [31:0] mAddr = BASE;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mFreeAt = 0; mWrAt = -1; mErrAt = -1; mCount = 0; mFull = 1'b0;
      mWord = 32'd0; mAddr = BASE;
    end else if (start) begin
      mWrAt = -1; mErrAt = -1; mCount = 0; mFull = 1'b0; mFreeAt = cyc + 1;
    end else begin
      if (in_valid && !mFull && cyc >= mFreeAt) begin
        if (fmt == 2'b11) begin
          mErrAt = cyc + 1; mFreeAt = cyc + 2;
        end else begin
          mWrAt = cyc + 2; mFreeAt = cyc + 3;
          mPend = encodeWord(fmt, opcode, rs, rt, rd, shamt, funct, immediate_data, jump_target);
        end
      end
      if (mWrAt == cyc + 1) begin
        mWord = mPend;
        mAddr = BASE + 32'(mCount) * 4;
      end
      if (mWrAt == cyc) begin
        mCount++;
        if (mCount == DEPTH) mFull = 1'b1;
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    checkOutput("model_ready", 32'(in_ready), 32'(!mFull && cyc >= mFreeAt && !start));
    checkOutput("model_wr_en", 32'(mem_wr_en), 32'(mWrAt == cyc && !start));
    checkOutput("model_err", 32'(err_fmt), 32'(mErrAt == cyc && !start));
    checkOutput("model_full", 32'(full), 32'(mFull));
    checkOutput("model_count", 32'(instr_count), 32'(mCount));
    checkOutput("model_wdata", mem_wdata, mWord);
    checkOutput("model_addr", mem_addr, mAddr);
  end

  task automatic applyStimulus(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] im, input logic [25:0] tg);
    bit accepted;
    @(negedge clk);
    fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
    immediate_data = im; jump_target = tg;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expectWrite(input string name, input logic [31:0] addr, input logic [31:0] data,
      input int countAfter);
    @(posedge clk); #2;
    checkOutput({name, "_wr_en"}, 32'(mem_wr_en), 32'd1);
    checkOutput({name, "_addr"}, mem_addr, addr);
    checkOutput({name, "_wdata"}, mem_wdata, data);
    @(posedge clk); #2;
    checkOutput({name, "_wr_done"}, 32'(mem_wr_en), 32'd0);
    checkOutput({name, "_count"}, 32'(instr_count), 32'(countAfter));
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_ready"}, 32'(in_ready), 32'd1);
    checkOutput({name, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    checkOutput({name, "_addr"}, mem_addr, BASE);
    checkOutput({name, "_wdata"}, mem_wdata, 32'd0);
    checkOutput({name, "_count"}, 32'(instr_count), 32'd0);
    checkOutput({name, "_full"}, 32'(full), 32'd0);
    checkOutput({name, "_err"}, 32'(err_fmt), 32'd0);
  endtask

  logic [31:0] wrAddrs[$];

  initial begin
    repeat (3) @(negedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] I-type addi-style word");
    applyStimulus(2'b01, 6'd8, 5'd9, 5'd9, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
    expectWrite("itype", 32'h0040_0000, 32'h2129_0004, 1);

    $display("[TB] R-type add word");
    applyStimulus(2'b00, 6'd0, 5'd9, 5'd8, 5'd10, 5'd0, 6'h20, 16'hFFFF, 26'd0);
    expectWrite("rtype", 32'h0040_0004, 32'h0128_5020, 2);

    $display("[TB] J-type word");
    applyStimulus(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000);
    expectWrite("jtype", 32'h0040_0008, 32'h0810_0000, 3);

    $display("[TB] illegal format");
    applyStimulus(2'b11, 6'd4, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'd6, 26'd7);
    #1;
    checkOutput("illegal_err", 32'(err_fmt), 32'd1);
    checkOutput("illegal_no_wr", 32'(mem_wr_en), 32'd0);
    @(posedge clk); #2;
    checkOutput("illegal_err_off", 32'(err_fmt), 32'd0);
    checkOutput("illegal_no_wr2", 32'(mem_wr_en), 32'd0);
    checkOutput("illegal_count", 32'(instr_count), 32'd3);
    checkOutput("illegal_wdata", mem_wdata, 32'h0810_0000);

    $display("[TB] fill memory with back-to-back requests");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fmt = 2'b01; opcode = 6'd8; rs = 5'd1; rt = 5'd2; immediate_data = 16'h1234;
    in_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #2;
      if (mem_wr_en) wrAddrs.push_back(mem_addr);
    end
    checkOutput("fill_writes", 32'(wrAddrs.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wrAddrs.size()) checkOutput("fill_addr", wrAddrs[i], BASE + 32'(i) * 4);
    end
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_ready", 32'(in_ready), 32'd0);
    checkOutput("fill_count", 32'(instr_count), 32'd4);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("restart_full", 32'(full), 32'd0);
    checkOutput("restart_count", 32'(instr_count), 32'd0);
    checkOutput("restart_ready", 32'(in_ready), 32'd1);
    applyStimulus(2'b00, 6'd0, 5'd9, 5'd8, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0);
    expectWrite("restart", 32'h0040_0000, 32'h0128_5020, 1);

    $display("[TB] reset during encode");
    applyStimulus(2'b01, 6'd8, 5'd9, 5'd9, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
    reset = 1'b1;
    #1;
    checkResetValues("midreset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      checkOutput("midreset_no_wr", 32'(mem_wr_en), 32'd0);
    end
    checkOutput("midreset_count", 32'(instr_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
